// File: rtl/uart_prog_loader.sv
// UART (8N1) program loader: receives a header N plus N bytes and writes them into the program RAM,
// holding the CPU in reset until the load completes. Define CHECKSUM_EN to require a trailing checksum byte.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit AUTO_RUN     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       we,
  output logic [7:0] w_addr,
  output logic [7:0] w_data,
  output logic       cpu_rst_n,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // state    | meaning
  // L_IDLE   | waiting for a header byte, CPU held in reset
  // L_LOAD   | writing program bytes, remain_q still to come
  // L_CHK    | waiting for the checksum byte (CHECKSUM_EN only)
  // L_RUN    | CPU running; a new byte restarts a load
  // L_ERR    | framing or checksum error, sticky until rst_n
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_LOAD, L_CHK, L_RUN, L_ERR} ld_state_t;

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  ld_state_t       state_q, state_d;
  logic [8:0]      remain_q, remain_d;
  logic            we_q, we_d;
  logic [7:0]      w_addr_q, w_addr_d;
  logic [7:0]      w_data_q, w_data_d;
  logic            cpu_rst_n_q, cpu_rst_n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
`ifdef CHECKSUM_EN
  logic [7:0]      sum_q, sum_d;
`endif

  // Receiver: half-bit count from the falling edge, then full-bit counts to each bit centre.
  always_comb begin
    rx_state_d   = rx_state_q;
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          bit_cnt_d  = HALF_TC;
        end
      end
      RX_START: begin
        if (bit_cnt_q == '0) begin
          if (!rx_sync_q) begin
            rx_state_d = RX_DATA;
            bit_cnt_d  = BIT_TC;
            bit_idx_d  = 3'd0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_ONE;
        end
      end
      RX_DATA: begin
        if (bit_cnt_q == '0) begin
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = BIT_TC;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_ONE;
        end
      end
      RX_STOP: begin
        if (bit_cnt_q == '0) begin
          byte_valid_d = rx_sync_q;
          frame_err_d  = !rx_sync_q;
          rx_state_d   = RX_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    we_d     = 1'b0;
    w_data_d = w_data_q;
    w_addr_d = we_q ? w_addr_q + 8'd1 : w_addr_q;
`ifdef CHECKSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      L_IDLE, L_RUN: begin
        if (byte_valid_q) begin
          state_d  = L_LOAD;
          w_addr_d = 8'd0;
          remain_d = (shift_q == 8'd0) ? 9'd256 : {1'b0, shift_q};
`ifdef CHECKSUM_EN
          sum_d    = 8'd0;
`endif
        end
      end
      L_LOAD: begin
        if (frame_err_q) begin
          state_d = L_ERR;
        end else if (byte_valid_q) begin
          we_d     = 1'b1;
          w_data_d = shift_q;
          remain_d = remain_q - 9'd1;
`ifdef CHECKSUM_EN
          sum_d    = sum_q + shift_q;
          if (remain_q == 9'd1) state_d = L_CHK;
`else
          if (remain_q == 9'd1) state_d = L_RUN;
`endif
        end
      end
`ifdef CHECKSUM_EN
      L_CHK: begin
        if (frame_err_q) begin
          state_d = L_ERR;
        end else if (byte_valid_q) begin
          state_d = (shift_q == sum_q) ? L_RUN : L_ERR;
        end
      end
`endif
      L_ERR:   state_d = L_ERR;
      default: state_d = L_ERR;
    endcase

    cpu_rst_n_d = (state_d == L_RUN);
    busy_d      = (state_d == L_LOAD) || (state_d == L_CHK);
    err_d       = (state_d == L_ERR);
    // done marks a completed load only, so an AUTO_RUN start leaves it low.
    done_d      = done_q;
    if (state_d != L_RUN)                            done_d = 1'b0;
    else if (state_q != L_RUN)                       done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= AUTO_RUN ? L_RUN : L_IDLE;
      remain_q    <= 9'd0;
      we_q        <= 1'b0;
      w_addr_q    <= 8'd0;
      w_data_q    <= 8'd0;
      cpu_rst_n_q <= AUTO_RUN;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      we_q        <= we_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign we        = we_q;
  assign w_addr    = w_addr_q;
  assign w_data    = w_data_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader at CLKS_PER_BIT=4; checksum byte appended when CHECKSUM_EN is defined.
module tb_uart_prog_loader;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ar = 1'b1;
  logic       we, cpu_rst_n, busy, done, err;
  logic [7:0] w_addr, w_data;
  logic       we_ar, cpu_rst_n_ar, busy_ar, done_ar, err_ar;
  logic [7:0] w_addr_ar, w_data_ar;

  int checks = 0;
  int errors = 0;
  logic [15:0] wlog[$];
  logic [7:0]  prog[256];

  always #5 clk = ~clk;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .AUTO_RUN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .we(we), .w_addr(w_addr), .w_data(w_data),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err));

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .AUTO_RUN(1'b1)) dut_ar (
    .clk(clk), .rst_n(rst_n), .rx(rx_ar), .we(we_ar), .w_addr(w_addr_ar), .w_data(w_data_ar),
    .cpu_rst_n(cpu_rst_n_ar), .busy(busy_ar), .done(done_ar), .err(err_ar));

  always @(negedge clk) if (we === 1'b1) wlog.push_back({w_addr, w_data});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic send_load(input logic [7:0] hdr, input int n);
    logic [7:0] sum;
    sum = 8'd0;
    send_byte(hdr, 1'b1);
    for (int i = 0; i < n; i++) begin
      send_byte(prog[i], 1'b1);
      sum = sum + prog[i];
    end
`ifdef CHECKSUM_EN
    send_byte(sum, 1'b1);
`endif
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_addr"}, 32'(w_addr), 32'd0);
    check({tag, "_data"}, 32'(w_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_cpu"}, 32'(cpu_rst_n), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    wlog.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] sum;
    bit seen;
    #2 rst_n = 1'b0;
    #1;
    check_reset("por");
    check("ar_cpu", 32'(cpu_rst_n_ar), 32'd1);
    check("ar_done", 32'(done_ar), 32'd0);
    check("ar_busy", 32'(busy_ar), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: basic two-byte load
    check("t1_idle_busy", 32'(busy), 32'd0);
    send_byte(8'h02, 1'b1);
    @(negedge clk);
    check("t1_hdr_busy", 32'(busy), 32'd1);
    check("t1_hdr_cpu", 32'(cpu_rst_n), 32'd0);
    send_byte(8'h60, 1'b1);
    @(negedge clk);
    check("t1_b0_busy", 32'(busy), 32'd1);
    check("t1_b0_done", 32'(done), 32'd0);
    send_byte(8'h80, 1'b1);
`ifdef CHECKSUM_EN
    send_byte(8'hE0, 1'b1);
`endif
    @(negedge clk);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_done", 32'(done), 32'd1);
    check("t1_cpu", 32'(cpu_rst_n), 32'd1);
    check("t1_nwr", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      check("t1_wr0", 32'(wlog[0]), 32'h0060);
      check("t1_wr1", 32'(wlog[1]), 32'h0180);
    end
    check("t1_addr", 32'(w_addr), 32'd2);
    wlog.delete();

    // 7: new header while running
    seen = 1'b0;
    fork
      send_byte(8'h01, 1'b1);
      begin
        for (int i = 0; i < 200 && !seen; i++) begin
          @(negedge clk);
          if (dut.byte_valid_q) seen = 1'b1;
        end
        check("t7_bv_seen", 32'(seen), 32'd1);
        check("t7_cpu_still", 32'(cpu_rst_n), 32'd1);
        @(negedge clk);
        check("t7_cpu_low", 32'(cpu_rst_n), 32'd0);
        check("t7_done_low", 32'(done), 32'd0);
      end
    join
    prog[0] = 8'h90;
    send_byte(8'h90, 1'b1);
`ifdef CHECKSUM_EN
    send_byte(8'h90, 1'b1);
`endif
    @(negedge clk);
    check("t7_nwr", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) check("t7_wr0", 32'(wlog[0]), 32'h0090);
    check("t7_cpu", 32'(cpu_rst_n), 32'd1);
    check("t7_done", 32'(done), 32'd1);
    wlog.delete();

    // 2: 256-byte load, header 0
    for (int i = 0; i < 256; i++) prog[i] = 8'(i);
    send_load(8'h00, 256);
    check("t2_nwr", 32'(wlog.size()), 32'd256);
    if (wlog.size() == 256)
      for (int i = 0; i < 256; i++) check("t2_wr", 32'(wlog[i]), 32'({8'(i), 8'(i)}));
    check("t2_addr_wrap", 32'(w_addr), 32'd0);
    check("t2_done", 32'(done), 32'd1);

    // 3: framing error mid-load
    do_reset();
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    @(negedge clk);
    check("t3_nwr", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) check("t3_wr0", 32'(wlog[0]), 32'h0011);
    check("t3_err", 32'(err), 32'd1);
    check("t3_cpu", 32'(cpu_rst_n), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h33, 1'b1);
    @(negedge clk);
    check("t3_ign_nwr", 32'(wlog.size()), 32'd1);
    check("t3_ign_err", 32'(err), 32'd1);
    check("t3_ign_done", 32'(done), 32'd0);

    // 4: one-cycle glitch in IDLE
    do_reset();
    @(posedge clk);
    rx = 1'b0;
    @(posedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    check("t4_nwr", 32'(wlog.size()), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_cpu", 32'(cpu_rst_n), 32'd0);
    check("t4_err", 32'(err), 32'd0);

    // 6: reset during the 2nd program byte
    send_byte(8'h03, 1'b1);
    send_byte(8'hA1, 1'b1);
    rx = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("t6_mid");
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    wlog.delete();
    prog[0] = 8'hA0;
    send_load(8'h01, 1);
    check("t6_nwr", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) check("t6_wr0", 32'(wlog[0]), 32'h00A0);
    check("t6_done", 32'(done), 32'd1);

`ifdef CHECKSUM_EN
    // 5: checksum good, then bad
    do_reset();
    send_byte(8'h01, 1'b1);
    send_byte(8'h60, 1'b1);
    send_byte(8'h60, 1'b1);
    @(negedge clk);
    check("t5_good_done", 32'(done), 32'd1);
    check("t5_good_err", 32'(err), 32'd0);
    do_reset();
    send_byte(8'h01, 1'b1);
    send_byte(8'h60, 1'b1);
    send_byte(8'h61, 1'b1);
    @(negedge clk);
    check("t5_bad_err", 32'(err), 32'd1);
    check("t5_bad_cpu", 32'(cpu_rst_n), 32'd0);
    check("t5_bad_done", 32'(done), 32'd0);
`endif

    check("ar_end_cpu", 32'(cpu_rst_n_ar), 32'd1);
    check("ar_end_done", 32'(done_ar), 32'd0);
    check("ar_end_we", 32'(we_ar), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
